// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues word reads over a
// req/gnt/rvalid handshake and drives the IF/ID register. A one-entry
// skid buffer catches a response that lands while decode is stalled.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4
);

  logic [31:0] pc;
  logic [31:0] inflight_pc;
  logic        outstanding;
  logic        drop;
  logic        buf_valid;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc;

  logic slot_free;
  logic grant;
  logic rsp_keep;
  logic load_rsp;
  logic fill_buf;
  logic load_buf;

  // IF/ID can take a new word when it is empty or decode is consuming it.
  assign slot_free = !if_id_valid || !stall;

  // A new request may overlap the returning response only when that
  // response has somewhere to go, which keeps occupancy at most two.
  assign imem_req  = !redirect_valid && !buf_valid &&
                     (!outstanding || (imem_rvalid && slot_free));
  assign imem_addr = pc;
  assign grant     = imem_req && imem_gnt;

  // Response routing; a redirect or a pending drop discards the word.
  assign rsp_keep = imem_rvalid && !drop && !redirect_valid;
  assign load_rsp = rsp_keep && slot_free;
  assign fill_buf = rsp_keep && !slot_free;
  // The buffer never coexists with a response: no request is issued
  // while it is full.
  assign load_buf = buf_valid && slot_free && !redirect_valid;

  // PC, in-flight tracking and the drop flag for stale responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      inflight_pc <= 32'h0;
      outstanding <= 1'b0;
      drop        <= 1'b0;
    end else if (redirect_valid) begin
      // Low two bits of the target are forced to zero.
      pc          <= redirect_pc & ~32'h3;
      outstanding <= outstanding && !imem_rvalid;
      drop        <= outstanding && !imem_rvalid;
    end else begin
      if (grant) begin
        pc          <= pc + 32'd4;
        inflight_pc <= pc;
        outstanding <= 1'b1;
      end else if (imem_rvalid) begin
        outstanding <= 1'b0;
      end
      if (imem_rvalid && drop)
        drop <= 1'b0;
    end
  end

  // Skid buffer: catches a response that arrives while IF/ID is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_instr <= NOP_INSTR;
      buf_pc    <= 32'h0;
    end else if (redirect_valid) begin
      buf_valid <= 1'b0;
    end else if (fill_buf) begin
      buf_valid <= 1'b1;
      buf_instr <= imem_rdata;
      buf_pc    <= inflight_pc;
    end else if (load_buf) begin
      buf_valid <= 1'b0;
    end
  end

  // IF/ID register: flush on redirect, load response or buffer, else bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_id_valid    <= 1'b0;
      if_id_instr    <= NOP_INSTR;
      if_id_pc       <= 32'h0;
      if_id_pc_plus4 <= 32'd4;
    end else if (redirect_valid) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
    end else if (load_rsp) begin
      if_id_valid    <= 1'b1;
      if_id_instr    <= imem_rdata;
      if_id_pc       <= inflight_pc;
      if_id_pc_plus4 <= inflight_pc + 32'd4;
    end else if (load_buf) begin
      if_id_valid    <= 1'b1;
      if_id_instr    <= buf_instr;
      if_id_pc       <= buf_pc;
      if_id_pc_plus4 <= buf_pc + 32'd4;
    end else if (slot_free) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a small memory model answers grants,
// a scoreboard queue holds the hand-computed instruction stream and a
// monitor pops it whenever decode consumes a valid IF/ID word.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   mem_lat  = 1;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus4 (if_id_pc_plus4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h02A3_0293;
      32'h4:   return 32'h0031_00B3;
      32'h8:   return 32'h0101_2503;
      default: return a ^ 32'hA500_0013;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push(input logic [31:0] p, input logic [31:0] i, input logic [31:0] p4);
    exp_t e;
    e.pc = p; e.instr = i; e.pc4 = p4;
    exp_q.push_back(e);
  endtask

  // Inputs change on the falling edge; checks follow 3 time units later.
  task automatic cyc(input logic g, input logic s, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    imem_gnt = g; stall = s; redirect_valid = rv; redirect_pc = rpc;
    #3;
  endtask

  // Memory: one response per grant, mem_lat cycles later; cleared by reset.
  initial begin
    logic        pv1, pv2;
    logic [31:0] pa1, pa2;
    pv1 = 1'b0; pv2 = 1'b0; pa1 = 32'h0; pa2 = 32'h0;
    forever begin
      @(negedge clk);
      imem_rvalid = pv1 && !rst;
      imem_rdata  = pv1 ? mem_word(pa1) : 32'h0;
      pv1 = pv2; pa1 = pa2; pv2 = 1'b0;
      #4;
      if (rst) begin
        pv1 = 1'b0; pv2 = 1'b0; imem_rvalid = 1'b0;
      end else if (imem_req && imem_gnt) begin
        if (mem_lat == 1) begin pv1 = 1'b1; pa1 = imem_addr; end
        else              begin pv2 = 1'b1; pa2 = imem_addr; end
      end
    end
  end

  // Monitor: every word decode consumes must match the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (!rst && if_id_valid && !stall && !redirect_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL consume: unexpected pc=%h instr=%h, nothing expected", if_id_pc, if_id_instr);
        end else begin
          e = exp_q.pop_front();
          if (if_id_pc === e.pc && if_id_instr === e.instr && if_id_pc_plus4 === e.pc4)
            n_pass++;
          else
            $display("FAIL consume: got pc=%h instr=%h pc4=%h expected pc=%h instr=%h pc4=%h",
                     if_id_pc, if_id_instr, if_id_pc_plus4, e.pc, e.instr, e.pc4);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    #3;
    chk("rst_valid", {31'h0, if_id_valid}, 32'h0);
    chk("rst_instr", if_id_instr, NOP);
    chk("rst_pc", if_id_pc, 32'h0);
    chk("rst_pc4", if_id_pc_plus4, 32'h4);
    chk("rst_addr", imem_addr, 32'h0);

    // Stream three words back to back, then hold grant low for four cycles.
    push(32'h0, 32'h02A3_0293, 32'h4);
    push(32'h4, 32'h0031_00B3, 32'h8);
    push(32'h8, 32'h0101_2503, 32'hC);
    @(negedge clk);
    rst = 1'b0; imem_gnt = 1'b1; #3;                       // C1
    chk("c1_req", {31'h0, imem_req}, 32'h1);
    chk("c1_addr", imem_addr, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);                          // C2
    chk("c2_req", {31'h0, imem_req}, 32'h1);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);                          // C3
    chk("c3_req", {31'h0, imem_req}, 32'h1);
    chk("c3_addr", imem_addr, 32'h8);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);                          // C4
    cyc(1'b0, 1'b0, 1'b0, 32'h0);                          // C5
    cyc(1'b0, 1'b0, 1'b0, 32'h0);                          // C6
    chk("nognt_valid6", {31'h0, if_id_valid}, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);                          // C7
    chk("nognt_valid7", {31'h0, if_id_valid}, 32'h0);
    chk("nognt_addr", imem_addr, 32'hC);

    // Resume, then stall three cycles while the next word is in flight.
    push(32'hC,  32'hA500_001F, 32'h10);
    push(32'h10, 32'hA500_0003, 32'h14);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);                          // C8
    cyc(1'b1, 1'b0, 1'b0, 32'h0);                          // C9
    cyc(1'b1, 1'b1, 1'b0, 32'h0);                          // C10
    chk("stall_req10", {31'h0, imem_req}, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);                          // C11
    chk("stall_req11", {31'h0, imem_req}, 32'h0);
    chk("stall_hold_pc", if_id_pc, 32'hC);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);                          // C12
    chk("stall_req12", {31'h0, imem_req}, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);                          // C13
    chk("drain_req", {31'h0, imem_req}, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);                          // C14
    chk("drain_pc", if_id_pc, 32'h10);
    chk("resume_req", {31'h0, imem_req}, 32'h1);
    chk("resume_addr", imem_addr, 32'h14);

    // Redirect while a two-cycle fetch is in flight: the late word is dropped.
    cyc(1'b1, 1'b0, 1'b0, 32'h0);                          // C15
    mem_lat = 2;
    push(32'h100, 32'hA500_0113, 32'h104);
    push(32'h104, 32'hA500_0117, 32'h108);
    cyc(1'b1, 1'b0, 1'b1, 32'h100);                        // C16
    chk("redir_req", {31'h0, imem_req}, 32'h0);
    mem_lat = 1;
    cyc(1'b1, 1'b0, 1'b0, 32'h0);                          // C17
    chk("redir_next_req", {31'h0, imem_req}, 32'h1);
    chk("redir_next_addr", imem_addr, 32'h100);
    chk("flush_valid", {31'h0, if_id_valid}, 32'h0);
    chk("flush_instr", if_id_instr, NOP);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);                          // C18
    chk("drop_valid", {31'h0, if_id_valid}, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);                          // C19
    chk("redir_pc", if_id_pc, 32'h100);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);                          // C20

    // Redirect, rvalid and stall together; target's low bits are ignored.
    cyc(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE);                  // C21
    chk("rr_req", {31'h0, imem_req}, 32'h0);
    push(32'hFFFF_FFFC, 32'h5AFF_FFEF, 32'h0);
    push(32'h0,         32'h02A3_0293, 32'h4);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);                          // C22
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_req0", {31'h0, imem_req}, 32'h1);
    chk("rr_valid", {31'h0, if_id_valid}, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);                          // C23
    chk("wrap_addr1", imem_addr, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);                          // C24
    cyc(1'b1, 1'b0, 1'b0, 32'h0);                          // C25

    // Reset mid-stream: outputs return to reset values at once.
    @(negedge clk);
    rst = 1'b1; imem_gnt = 1'b0; #1;                       // C26
    chk("mrst_valid", {31'h0, if_id_valid}, 32'h0);
    chk("mrst_instr", if_id_instr, NOP);
    chk("mrst_pc", if_id_pc, 32'h0);
    chk("mrst_pc4", if_id_pc_plus4, 32'h4);
    chk("mrst_addr", imem_addr, 32'h0);

    push(32'h0, 32'h02A3_0293, 32'h4);
    @(negedge clk);
    rst = 1'b0; imem_gnt = 1'b1; #3;                       // C27
    chk("post_rst_req", {31'h0, imem_req}, 32'h1);
    chk("post_rst_addr", imem_addr, 32'h0);
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 32'h0);               // C28..C31

    chk("queue_empty", exp_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage RISC-V pipeline. Holds the PC and issues word reads to instruction memory over a req/gnt/rvalid handshake. Drives the IF/ID pipeline register that feeds `decode`. Supports stall from the hazard unit and redirect (branch/jump flush) from EX, and uses a one-entry skid buffer so no fetched word is lost under stall.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.
- `NOP_INSTR`, 32'h0000_0013, `addi x0,x0,0`; value driven on `if_id_instr` whenever IF/ID is invalid.

Ports (clock is `clk`; reset is `rst`, asynchronous, active-high):
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  async active-high reset.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  word address of the request, always equal to `pc`.
- `imem_gnt`  in  1  request accepted this cycle (valid only with `imem_req`).
- `imem_rvalid`  in  1  read data valid; exactly one per granted request, in order, at least 1 cycle after grant.
- `imem_rdata`  in  32  instruction word.
- `stall`  in  1  decode cannot accept; IF/ID must hold.
- `redirect_valid`  in  1  flush and restart fetch.
- `redirect_pc`  in  32  new PC; bits [1:0] ignored (treated as 0).
- `if_id_valid`  out  1  IF/ID holds a real instruction.
- `if_id_instr`  out  32  instruction to decode.
- `if_id_pc`  out  32  PC of `if_id_instr`.
- `if_id_pc_plus4`  out  32  `if_id_pc + 4` (mod 2^32).

## Operation
- State: `pc`, `outstanding` (0/1), `inflight_pc`, `drop` (discard next response), skid buffer (`buf_valid`, `buf_instr`, `buf_pc`), IF/ID register.
- `slot_free = !if_id_valid || !stall`.
- `imem_req = !redirect_valid && !buf_valid && (!outstanding || (imem_rvalid && slot_free))`. At most one request is outstanding, and total occupancy (IF/ID + buffer + in-flight) never exceeds 2.
- Grant (`imem_req && imem_gnt`): `pc <= pc+4` (wraps at 2^32), `inflight_pc <= pc`, `outstanding <= 1`. Ungranted requests carry no state; `imem_addr` holds `pc` until grant.
- Response (`imem_rvalid`, no grant same cycle): `outstanding <= 0`.
  - If `drop`: discard the response and clear `drop`.
  - Else if `slot_free`: load IF/ID with {1, rdata, inflight_pc}.
  - Else: load the buffer.
- Buffer drain: if `buf_valid && slot_free`, load IF/ID from the buffer and clear `buf_valid`. A response cannot coincide with this, because no request is issued while `buf_valid`.
- If `slot_free` and nothing loads: `if_id_valid <= 0`, `if_id_instr <= NOP_INSTR` (bubble).
- `stall` with nothing new: IF/ID holds all fields.
- Redirect has priority over everything:
  - `pc <= {redirect_pc[31:2],2'b00}`.
  - `if_id_valid <= 0`, instr `<= NOP_INSTR`, `buf_valid <= 0`.
  - `imem_req = 0`.
  - An rvalid arriving in the redirect cycle is discarded.
  - If `outstanding && !imem_rvalid`: `drop <= 1`.
  - `stall` is ignored in the redirect cycle.
- Reset: `pc = RESET_PC`, `outstanding = drop = buf_valid = 0`, `if_id_valid = 0`, `if_id_instr = NOP_INSTR`, `if_id_pc = 0`, `if_id_pc_plus4 = 4`, `imem_req` = 1 in the first cycle after deassertion. Mid-operation reset abandons any in-flight response. The memory must be reset with the block.

## Timing
- Grant in cycle N, rvalid in N+1: `if_id_valid` is high from N+2 with `if_id_pc = inflight_pc`.
- Best-case throughput is 1 instruction/cycle: gnt every cycle and rvalid one cycle later. A new request is issued in the same cycle as the previous rvalid.
- After redirect in cycle R: a request to the new PC is issued in R+1. Its instruction is valid in IF/ID no earlier than R+3.
- Stall releases with buffer full: the buffer word enters IF/ID on the next edge, and fetch resumes one cycle later.
- All outputs are registered except `imem_req` and `imem_addr`. `imem_req` is combinational from `redirect_valid`, `imem_rvalid` and `stall`.

## Test plan
- Reset then stream; memory returns `02A30293`, `003100B3`, `01012503` with gnt=1 and 1-cycle rvalid -> IF/ID shows these on consecutive cycles, PCs 0,4,8, pc_plus4 4,8,C; `imem_req` high continuously.
- Assert `stall` for 3 cycles while the word at PC 4 is in flight -> IF/ID holds PC 0. The word at PC 4 goes to the buffer and `imem_req` drops. On release, PC 4 appears next cycle and the PC 8 request issues one cycle later. No loss or duplication.
- Redirect to `0x100` while the PC 8 request is in flight (rvalid one cycle later) -> the late `01012503` is dropped. IF/ID is invalid with NOP, and the next valid instruction has PC `0x100`.
- Redirect and rvalid in the same cycle, together with `stall`=1 -> the response is discarded, the buffer is cleared, and the next fetch address is the redirect target.
- `imem_gnt` held low for 4 cycles -> `imem_addr` stable, `pc` unchanged, `if_id_valid` drops to 0 after draining, and fetch resumes correctly on grant.
- Redirect to `0xFFFF_FFFC` and fetch twice -> second fetch address wraps to `0x0000_0000`. Assert `rst` mid-stream -> all outputs at reset values immediately.
